// File: rtl/serial_operand_unit_if.sv
// Serial operand unit bus.
// Groups the per-digit control, data and status signals of serial_operand_unit.
//   start     : one-cycle pulse on digit 0 of a minor cycle
//   op        : 00 NOP, 01 ADD, 10 SUB, 11 COLL (sampled with start)
//   long_n    : 1 = long (DATA_BITS) operand, 0 = short (SHORT_BITS) operand
//   mcand     : multiplicand digit, LSB first
//   mplier    : multiplier digit, aligned with mcand
//   adder_b   : serial operand to the adder B input
//   busy      : a minor cycle is running or still draining the output pipe
//   done      : pulse while adder_b carries the last (guard) digit
//   start_err : pulse when a start arrives mid-cycle and is ignored
// master drives the stimulus side, slave is the operand unit itself.
interface serial_operand_unit_if;
    logic       start;
    logic [1:0] op;
    logic       long_n;
    logic       mcand;
    logic       mplier;
    logic       adder_b;
    logic       busy;
    logic       done;
    logic       start_err;

    modport master (
        output start, op, long_n, mcand, mplier,
        input  adder_b, busy, done, start_err
    );

    modport slave (
        input  start, op, long_n, mcand, mplier,
        output adder_b, busy, done, start_err
    );
endinterface

// File: rtl/serial_operand_unit.sv
// Serial operand unit.
// Builds the serial B operand for the adder one digit per clock, LSB first, from the
// multiplicand/multiplier streams. Each minor cycle is WORD_BITS digits: a data region
// (long or short word), a sign-extension region up to DATA_BITS, then a guard gap of
// zeros. The digit stream passes through OUT_DELAY register stages before adder_b.
// Ports:
//   clk   : digit-pulse clock
//   reset : asynchronous reset, active-high
//   bus   : serial_operand_unit_if.slave (start/op/long_n/mcand/mplier in,
//           adder_b/busy/done/start_err out)
module serial_operand_unit #(
    parameter int unsigned WORD_BITS  = 36,
    parameter int unsigned DATA_BITS  = 35,
    parameter int unsigned SHORT_BITS = 17,
    parameter int unsigned OUT_DELAY  = 1
) (
    input logic                  clk,
    input logic                  reset,
    serial_operand_unit_if.slave bus
);

    localparam int unsigned KW = $clog2(WORD_BITS);
    typedef logic [KW-1:0] k_t;

    localparam k_t KLast  = k_t'(WORD_BITS - 1);
    localparam k_t LLong  = k_t'(DATA_BITS);
    localparam k_t LShort = k_t'(SHORT_BITS);

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpAdd  = 2'b01;
    localparam logic [1:0] OpSub  = 2'b10;
    localparam logic [1:0] OpColl = 2'b11;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;
    k_t     k_q, k_d;          // index of the digit handled at the next edge while running
    logic [1:0] op_q, op_d;
    logic   long_q, long_d;
    logic   neg_q, neg_d;
    logic   sign_q, sign_d;
    logic   err_q, err_d;

    logic [OUT_DELAY-1:0] data_q, data_d;
    logic [OUT_DELAY-1:0] vld_q, vld_d;
    logic [OUT_DELAY-1:0] last_q, last_d;

    // Digit k is processed at the k-th edge after (and including) the start edge.
    // The counter goes idle right after the guard digit, so a start on the following
    // edge lands in StIdle and is accepted: that is the back-to-back case.
    logic accept;
    assign accept = bus.start && (state_q == StIdle);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    k_d     = k_t'(1);
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    state_d = StIdle;
                    k_d     = '0;
                end else begin
                    k_d = k_q + k_t'(1);
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- digit datapath
    logic       cur_run;
    k_t         cur_k;
    k_t         cur_l;
    logic [1:0] cur_op;
    logic       cur_long;
    logic       cur_neg;
    logic       in_data;
    logic       digit;

    always_comb begin
        // On the start edge the digit uses the freshly presented op/long_n and a clear neg.
        cur_run  = accept || (state_q == StRun);
        cur_k    = accept ? '0 : k_q;
        cur_op   = accept ? bus.op : op_q;
        cur_long = accept ? bus.long_n : long_q;
        cur_neg  = accept ? 1'b0 : neg_q;
        cur_l    = cur_long ? LLong : LShort;
        in_data  = cur_run && (cur_k < cur_l);

        digit = 1'b0;
        if (in_data) begin
            unique case (cur_op)
                OpNop:  digit = 1'b0;
                OpAdd:  digit = bus.mcand;
                // Two's complement: copy up to and including the first 1, invert after.
                OpSub:  digit = bus.mcand ^ cur_neg;
                OpColl: digit = bus.mcand & bus.mplier;
            endcase
        end else if (cur_run && (cur_k < LLong)) begin
            digit = sign_q;
        end

        op_d   = accept ? bus.op : op_q;
        long_d = accept ? bus.long_n : long_q;

        neg_d = cur_neg;
        if (in_data && (cur_op == OpSub) && bus.mcand) begin
            neg_d = 1'b1;
        end

        sign_d = sign_q;
        if (in_data && (cur_k == cur_l - k_t'(1))) begin
            sign_d = digit;
        end

        err_d = bus.start && (state_q == StRun);

        data_d    = data_q << 1;
        data_d[0] = digit;
        vld_d     = vld_q << 1;
        vld_d[0]  = cur_run;
        last_d    = last_q << 1;
        last_d[0] = cur_run && (cur_k == KLast);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            long_q <= 1'b0;
            neg_q  <= 1'b0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            op_q   <= op_d;
            long_q <= long_d;
            neg_q  <= neg_d;
            sign_q <= sign_d;
            err_q  <= err_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.adder_b   = data_q[OUT_DELAY-1];
        bus.done      = vld_q[OUT_DELAY-1] && last_q[OUT_DELAY-1];
        bus.busy      = (state_q == StRun) || (|vld_q);
        bus.start_err = err_q;
    end

endmodule
